// File: rtl/syn_wm8731_i2c_slave.sv
// Write-only I2C slave for WM8731-style 7-bit address / 9-bit data register writes.
// Handshake: wr_valid_o is a one-cycle strobe qualifying wr_addr_o/wr_data_o; no ready, the consumer must take it.
module syn_wm8731_i2c_slave #(
  parameter logic [6:0] P_DEV_ADDR    = 7'h1A,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic       clk_ir,
  input  logic       rst_ih,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  input  logic [6:0] rd_addr_i,
  output logic [8:0] rd_data_o,
  output logic       wr_valid_o,
  output logic [6:0] wr_addr_o,
  output logic [8:0] wr_data_o,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
  } state_t;

  state_t                   state_q, state_d;
  logic [P_SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [P_SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                     scl_prev_q, sda_prev_q;
  logic [2:0]               cnt_q, cnt_d;
  logic                     full_q, full_d;
  logic [7:0]               shift_q, shift_d;
  logic [6:0]               reg_addr_q, reg_addr_d;
  logic                     data8_q, data8_d;
  logic [7:0]               data_lo_q, data_lo_d;
  logic                     commit_q, commit_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     busy_q, busy_d;
  logic                     wr_valid_q, wr_valid_d;
  logic [6:0]               wr_addr_q, wr_addr_d;
  logic [8:0]               wr_data_q, wr_data_d;
  logic [8:0]               regfile_q [16];
  logic [8:0]               regfile_d [16];

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[P_SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[P_SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    scl_sync_d[0] = scl_i;
    sda_sync_d[0] = sda_i;
    for (int i = 1; i < P_SYNC_STAGES; i++) begin
      scl_sync_d[i] = scl_sync_q[i-1];
      sda_sync_d[i] = sda_sync_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    data8_d    = data8_q;
    data_lo_d  = data_lo_q;
    commit_d   = 1'b0;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regfile_d  = regfile_q;

    // Commit lands one cycle after the BYTE2 fall; register 0x0F wipes the whole file.
    if (commit_q) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = reg_addr_q;
      wr_data_d  = {data8_q, data_lo_q};
      if (reg_addr_q == 7'h0F) begin
        for (int i = 0; i < 16; i++) regfile_d[i] = '0;
      end else if (reg_addr_q[6:4] == 3'd0) begin
        regfile_d[reg_addr_q[3:0]] = {data8_q, data_lo_q};
      end
    end

    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      full_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) full_d = 1'b1;
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q == {P_DEV_ADDR, 1'b0}) begin
                state_d  = ADDR_ACK;
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == BYTE1) begin
              reg_addr_d = shift_q[7:1];
              data8_d    = shift_q[0];
              state_d    = ACK1;
              sda_oe_d   = 1'b1;
            end else begin
              data_lo_d = shift_q;
              commit_d  = 1'b1;
              state_d   = ACK2;
              sda_oe_d  = 1'b1;
            end
          end
        end
        ADDR_ACK, ACK1, ACK2: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            full_d   = 1'b0;
            state_d  = (state_q == ACK1) ? BYTE2 : BYTE1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      data8_q    <= 1'b0;
      data_lo_q  <= '0;
      commit_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < 16; i++) regfile_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      data8_q    <= data8_d;
      data_lo_q  <= data_lo_d;
      commit_q   <= commit_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      regfile_q  <= regfile_d;
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign busy_o      = busy_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign rd_data_o   = regfile_q[rd_addr_i[3:0]];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_syn_wm8731_i2c_slave.sv
// Bench for syn_wm8731_i2c_slave: bit-level I2C master tasks, register-file model and write scoreboard.
module tb_syn_wm8731_i2c_slave;

  localparam int         Q        = 5;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe_o;
  logic [6:0] rd_addr;
  logic [8:0] rd_data_o;
  logic       wr_valid_o;
  logic [6:0] wr_addr_o;
  logic [8:0] wr_data_o;
  logic       busy_o;
  logic [2:0] dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [8:0]  model[16];

  assign sda_line = sda_m & ~sda_oe_o;

  syn_wm8731_i2c_slave #(.P_DEV_ADDR(7'h1A), .P_SYNC_STAGES(2)) dut (
    .clk_ir(clk), .rst_ih(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(sda_oe_o), .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog obs=timeout exp=finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) if (wr_valid_o) obs_q.push_back({wr_addr_o, wr_data_o});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  task automatic model_write(input logic [6:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
    if (a == 7'h0F) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
    end else if (a < 7'd16) begin
      model[a[3:0]] = d;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic compare_writes();
    int n;
    check("wr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("wr_entry", 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 7'(i);
      #1;
      check("rd_data", 32'(rd_data_o), 32'(model[i]));
    end
  endtask

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i]; wait_q();
      scl_m = 1'b1;   wait_q();
      check("oe_during_data", 32'(sda_oe_o), 32'd0);
      wait_q();
      scl_m = 1'b0;   wait_q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    ack = sda_oe_o;
    wait_q();
    scl_m = 1'b0; wait_q();
    check("ack_release", 32'(sda_oe_o), 32'd0);
  endtask

  logic       ack;
  logic       good, abort;
  logic [7:0] addr_byte;
  logic [6:0] ra;
  logic [8:0] dv;
  int         npairs;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_oe", 32'(sda_oe_o), 32'd0);
    check("rst_valid", 32'(wr_valid_o), 32'd0);
    check("rst_waddr", 32'(wr_addr_o), 32'd0);
    check("rst_wdata", 32'(wr_data_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
    rst = 1'b0;
    wait_q();
    check_regs();

    // single write: reg 7 <= 0x04A
    i2c_start();
    send_byte(8'h34, ack); check("w1_ack_addr", 32'(ack), 32'd1);
    check("w1_busy", 32'(busy_o), 32'd1);
    send_byte(8'h0E, ack); check("w1_ack_b1", 32'(ack), 32'd1);
    send_byte(8'h4A, ack); check("w1_ack_b2", 32'(ack), 32'd1);
    i2c_stop(); wait_q();
    model_write(7'h07, 9'h04A);
    compare_writes();
    check("w1_busy_stop", 32'(busy_o), 32'd0);
    rd_addr = 7'h07; #1;
    check("w1_rd7", 32'(rd_data_o), 32'h04A);

    // wrong device address
    i2c_start();
    send_byte(8'h36, ack); check("na_ack_addr", 32'(ack), 32'd0);
    check("na_busy", 32'(busy_o), 32'd0);
    send_byte(8'h0E, ack); check("na_ack_b1", 32'(ack), 32'd0);
    send_byte(8'h11, ack); check("na_ack_b2", 32'(ack), 32'd0);
    i2c_stop(); wait_q();
    compare_writes();

    // streamed pair of writes
    i2c_start();
    send_byte(8'h34, ack); check("s_ack_addr", 32'(ack), 32'd1);
    send_byte(8'h05, ack); check("s_ack1", 32'(ack), 32'd1);
    send_byte(8'h55, ack); check("s_ack2", 32'(ack), 32'd1);
    send_byte(8'h07, ack); check("s_ack3", 32'(ack), 32'd1);
    send_byte(8'hFF, ack); check("s_ack4", 32'(ack), 32'd1);
    i2c_stop(); wait_q();
    model_write(7'h02, 9'h155);
    model_write(7'h03, 9'h1FF);
    compare_writes();
    check_regs();

    // reset register clears the file
    i2c_start();
    send_byte(8'h34, ack); send_byte(8'h04, ack); send_byte(8'hAA, ack);
    i2c_stop(); wait_q();
    model_write(7'h02, 9'h0AA);
    i2c_start();
    send_byte(8'h34, ack); send_byte(8'h1E, ack); send_byte(8'h00, ack);
    check("clr_ack", 32'(ack), 32'd1);
    i2c_stop(); wait_q();
    model_write(7'h0F, 9'h000);
    compare_writes();
    check_regs();

    // repeated START in the middle of BYTE2 discards the partial write
    i2c_start();
    send_byte(8'h34, ack); send_byte(8'h0E, ack);
    send_bits(8'h4A, 4);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    check("rs_state", 32'(dbg_state_o), 32'(ST_ADDR));
    scl_m = 1'b0; wait_q();
    compare_writes();
    send_byte(8'h34, ack); check("rs_ack_addr", 32'(ack), 32'd1);
    send_byte(8'h08, ack); send_byte(8'h3C, ack);
    i2c_stop(); wait_q();
    model_write(7'h04, 9'h03C);
    compare_writes();
    check_regs();

    // reset while ACK1 is driven
    i2c_start();
    send_byte(8'h34, ack);
    send_bits(8'h0E, 8);
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    check("ack1_driven", 32'(sda_oe_o), 32'd1);
    rst = 1'b1; #1;
    check("rst_async_oe", 32'(sda_oe_o), 32'd0);
    @(negedge clk);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_valid", 32'(wr_valid_o), 32'd0);
    check("rst_mid_waddr", 32'(wr_addr_o), 32'd0);
    check("rst_mid_wdata", 32'(wr_data_o), 32'd0);
    check("rst_mid_state", 32'(dbg_state_o), 32'(ST_IDLE));
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
    send_byte(8'h34, ack); check("post_rst_noack", 32'(ack), 32'd0);
    i2c_stop(); wait_q();
    compare_writes();
    check_regs();

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      good = ($urandom_range(0, 9) != 0);
      addr_byte = 8'h34;
      if (!good) begin
        do addr_byte = 8'($urandom_range(0, 255)); while (addr_byte == 8'h34);
      end
      i2c_start();
      send_byte(addr_byte, ack); check("r_ack_addr", 32'(ack), 32'(good));
      check("r_busy", 32'(busy_o), 32'(good));
      npairs = $urandom_range(1, 3);
      for (int p = 0; p < npairs; p++) begin
        ra = 7'($urandom_range(0, 31));
        dv = 9'($urandom_range(0, 511));
        send_byte({ra, dv[8]}, ack); check("r_ack_b1", 32'(ack), 32'(good));
        abort = (p == npairs - 1) && ($urandom_range(0, 4) == 0);
        if (abort) break;
        send_byte(dv[7:0], ack); check("r_ack_b2", 32'(ack), 32'(good));
        if (good) model_write(ra, dv);
      end
      i2c_stop(); wait_q();
      compare_writes();
      check("r_busy_stop", 32'(busy_o), 32'd0);
      rd_addr = 7'($urandom_range(0, 127)); #1;
      check("r_rd", 32'(rd_data_o), 32'(model[rd_addr[3:0]]));
    end
    check_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syn_wm8731_i2c_slave.md
SYN_WM8731_I2C_SLAVE -- requirements
Module: syn_wm8731_i2c_slave

Interface
REQ-001 SHALL have parameter P_DEV_ADDR, default 7'h1A, 7-bit I2C device address matched on the bus.
REQ-002 SHALL have parameter P_SYNC_STAGES, default 2, number of flops in the SCL/SDA input synchronisers.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all state changes on the rising edge of clk_ir.
REQ-004 clk_ir  input  1  system clock, at least 8x SCL frequency.
REQ-005 rst_ih  input  1  asynchronous active-high reset.
REQ-006 scl_i  input  1  I2C clock from the master, asynchronous to clk_ir.
REQ-007 sda_i  input  1  I2C data line as seen on the pad, asynchronous.
REQ-008 sda_oe_o  output  1  1 = drive SDA low (open drain); 0 = release.
REQ-009 rd_addr_i  input  7  register-file read address.
REQ-010 rd_data_o  output  9  combinational read of regfile[rd_addr_i[3:0]].
REQ-011 wr_valid_o  output  1  single-cycle pulse on each committed register write.
REQ-012 wr_addr_o  output  7  register address of the committed write, held until the next write.
REQ-013 wr_data_o  output  9  data of the committed write, held until the next write.
REQ-014 busy_o  output  1  high from an addressed START until STOP.

Function
REQ-015 Synchronisers: scl_i and sda_i SHALL each pass through P_SYNC_STAGES flops; edges are detected on the synchronised values (scl_rise, scl_fall).
REQ-016 START: synchronised SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both SHALL be recognised in any state, including mid-byte.
REQ-017 FSM states SHALL be IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE.
REQ-018 START -> ADDR with the bit counter cleared; STOP -> IDLE; a repeated START SHALL behave the same as a START.
REQ-019 Data SHALL be sampled MSB first on scl_rise; the bit counter counts 0..7.
REQ-020 After 8 address bits: {addr[6:0],rw} with addr==P_DEV_ADDR and rw==0 -> ADDR_ACK and busy_o=1; otherwise -> IGNORE with no ACK.
REQ-021 In IGNORE, sda_oe_o SHALL stay 0 until the next START or STOP.
REQ-022 ACK timing: sda_oe_o SHALL assert on the scl_fall that ends bit 8 and deassert on the next scl_fall.
REQ-023 BYTE1 SHALL capture {reg_addr[6:0], data[8]}, then ACK1; BYTE2 SHALL capture data[7:0], then ACK2.
REQ-024 Write commit SHALL happen one clk_ir cycle after the scl_fall that ends BYTE2: regfile written, wr_valid_o pulsed, wr_addr_o/wr_data_o updated.
REQ-025 After ACK2 the FSM SHALL return to BYTE1, so further byte pairs stream as additional writes.
REQ-026 A STOP or START after BYTE1 but before BYTE2 completes SHALL discard the partial write: no commit, no pulse.
REQ-027 Regfile: 16 x 9 bits, indexed by reg_addr[3:0]. Writes to reg_addr > 7'h0F SHALL be ACKed but not stored; wr_valid_o still pulses.
REQ-028 A write to reg_addr 7'h0F (reset register) SHALL clear all 16 entries to 0 in the same cycle as the commit; wr_valid_o pulses.
REQ-029 The slave is write-only; it SHALL never drive read data onto SDA.

Reset
REQ-030 While rst_ih=1: FSM=IDLE, counters=0, synchroniser flops=1 (idle bus), regfile=0, sda_oe_o=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0.
REQ-031 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and abort the transfer without a commit.
REQ-032 After reset release, the FSM SHALL ignore bus activity until the next START.

Verification
REQ-033 START, 0x34, 0x0E, 0x4A, STOP -> three ACKs; wr_valid_o pulses once; wr_addr_o=7'h07; wr_data_o=9'h04A; rd_data_o at addr 7 = 9'h04A.
REQ-034 START, 0x36 (address 0x1B) -> no ACK (sda_oe_o=0 for the whole transfer); no wr_valid_o; busy_o=0.
REQ-035 START, 0x34, 0x05, 0x55, 0x07, 0xFF, STOP -> two pulses: (addr 2, 9'h155), then (addr 3, 9'h1FF).
REQ-036 Write addr 2 = 9'h0AA, then START, 0x34, 0x1E, 0x00 -> all 16 registers read 0.
REQ-037 START, 0x34, 0x0E, then repeated START mid-BYTE2 -> no commit; FSM in ADDR; a following valid write commits normally.
REQ-038 rst_ih pulsed during ACK1 -> sda_oe_o=0 within the reset assertion; all outputs at reset values; no pulse.
